// File: rtl/hazard_pipe_tracker.sv
// Pipeline hazard tracker: carries destination register and result latency through E/M/W,
// owns the multiply/divide busy counter, and turns stalls into PC/F-D enables and a D/E bubble.
module hazard_pipe_tracker #(
   parameter int A3_W     = 5,
   parameter int T_W      = 3,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stop,
   input  logic [A3_W-1:0] D_A3,
   input  logic [T_W-1:0]  D_Tnew,
   input  logic [1:0]      D_md_start,
   input  logic            D_md_use,
   output logic [A3_W-1:0] E_A3,
   output logic [A3_W-1:0] M_A3,
   output logic [A3_W-1:0] W_A3,
   output logic [T_W-1:0]  E_Tnew,
   output logic [T_W-1:0]  M_Tnew,
   output logic [T_W-1:0]  W_Tnew,
   output logic            md_busy,
   output logic            stall,
   output logic            pc_en,
   output logic            fd_en,
   output logic            de_clr
);

   localparam int         CNT_W   = $clog2(DIV_CYC + 1);
   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   logic [A3_W-1:0]  e_a3_q, e_a3_d;
   logic [A3_W-1:0]  m_a3_q, m_a3_d;
   logic [A3_W-1:0]  w_a3_q, w_a3_d;
   logic [T_W-1:0]   e_tnew_q, e_tnew_d;
   logic [T_W-1:0]   m_tnew_q, m_tnew_d;
   logic [T_W-1:0]   w_tnew_q, w_tnew_d;
   logic             md_pending_q, md_pending_d;
   logic             md_div_q, md_div_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic             md_stall;
   logic             d_is_md_op;

   // Latency counts down toward zero and holds there; it must never wrap.
   function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
      return (x == '0) ? '0 : x - T_W'(1);
   endfunction

   // A stage writing $0 carries no latency, so it can never match a source operand.
   function automatic logic [T_W-1:0] norm_tnew(input logic [A3_W-1:0] a3,
                                                input logic [T_W-1:0]  tnew);
      return (a3 == '0) ? '0 : tnew;
   endfunction

   assign d_is_md_op = (D_md_start == MD_MULT) || (D_md_start == MD_DIV);
   assign md_busy    = (md_cnt_q != '0);
   assign md_stall   = D_md_use & (md_busy | md_pending_q);
   assign stall      = stop | md_stall;
   assign pc_en      = ~stall;
   assign fd_en      = ~stall;
   assign de_clr     = stall;

   always_comb begin
      e_a3_d   = stall ? '0 : D_A3;
      e_tnew_d = stall ? '0 : norm_tnew(D_A3, D_Tnew);
      m_a3_d   = e_a3_q;
      m_tnew_d = norm_tnew(e_a3_q, sat_dec(e_tnew_q));
      w_a3_d   = m_a3_q;
      w_tnew_d = norm_tnew(m_a3_q, sat_dec(m_tnew_q));
   end

   // The MDU op is latched as it enters E; the counter loads one edge later.
   always_comb begin
      md_pending_d = ~stall & d_is_md_op;
      md_div_d     = md_div_q;
      if (md_pending_d) begin
         md_div_d = (D_md_start == MD_DIV);
      end

      md_cnt_d = md_cnt_q;
      if (md_pending_q) begin
         md_cnt_d = md_div_q ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_a3_q       <= '0;
         e_tnew_q     <= '0;
         m_a3_q       <= '0;
         m_tnew_q     <= '0;
         w_a3_q       <= '0;
         w_tnew_q     <= '0;
         md_pending_q <= 1'b0;
         md_div_q     <= 1'b0;
         md_cnt_q     <= '0;
      end else begin
         e_a3_q       <= e_a3_d;
         e_tnew_q     <= e_tnew_d;
         m_a3_q       <= m_a3_d;
         m_tnew_q     <= m_tnew_d;
         w_a3_q       <= w_a3_d;
         w_tnew_q     <= w_tnew_d;
         md_pending_q <= md_pending_d;
         md_div_q     <= md_div_d;
         md_cnt_q     <= md_cnt_d;
      end
   end

   assign E_A3   = e_a3_q;
   assign M_A3   = m_a3_q;
   assign W_A3   = w_a3_q;
   assign E_Tnew = e_tnew_q;
   assign M_Tnew = m_tnew_q;
   assign W_Tnew = w_tnew_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Directed-vector bench for hazard_pipe_tracker: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_pipe_tracker;

   logic       clk;
   logic       reset;
   logic       stop;
   logic [4:0] D_A3;
   logic [2:0] D_Tnew;
   logic [1:0] D_md_start;
   logic       D_md_use;
   logic [4:0] E_A3, M_A3, W_A3;
   logic [2:0] E_Tnew, M_Tnew, W_Tnew;
   logic       md_busy, stall, pc_en, fd_en, de_clr;

   hazard_pipe_tracker #(
      .A3_W(5), .T_W(3), .MULT_CYC(5), .DIV_CYC(10)
   ) dut (
      .clk(clk), .reset(reset), .stop(stop),
      .D_A3(D_A3), .D_Tnew(D_Tnew), .D_md_start(D_md_start), .D_md_use(D_md_use),
      .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
      .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .W_Tnew(W_Tnew),
      .md_busy(md_busy), .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rst: 0 = run, 1 = reset held low for the whole cycle, 2 = short low pulse mid-cycle
   typedef struct {
      string      name;
      int         rst;
      logic       stop;
      logic [4:0] a3;
      logic [2:0] tnew;
      logic [1:0] ms;
      logic       mu;
      logic [4:0] ea3;
      logic [2:0] et;
      logic [4:0] ma3;
      logic [2:0] mt;
      logic [4:0] wa3;
      logic [2:0] wt;
      logic       busy;
      logic       st;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic add(input string n, input int rst, input logic stp,
                      input logic [4:0] a3, input logic [2:0] t, input logic [1:0] ms, input logic mu,
                      input logic [4:0] ea, input logic [2:0] et, input logic [4:0] ma, input logic [2:0] mt,
                      input logic [4:0] wa, input logic [2:0] wt, input logic busy, input logic st);
      vec_t v;
      v.name = n; v.rst = rst; v.stop = stp; v.a3 = a3; v.tnew = t; v.ms = ms; v.mu = mu;
      v.ea3 = ea; v.et = et; v.ma3 = ma; v.mt = mt; v.wa3 = wa; v.wt = wt; v.busy = busy; v.st = st;
      vecs.push_back(v);
   endtask

   task automatic check(input vec_t e);
      logic [31:0] act, req;
      act = {E_A3, E_Tnew, M_A3, M_Tnew, W_A3, W_Tnew, md_busy, stall, pc_en, fd_en, de_clr};
      req = {e.ea3, e.et, e.ma3, e.mt, e.wa3, e.wt, e.busy, e.st, ~e.st, ~e.st, e.st};
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got E=%0d/%0d M=%0d/%0d W=%0d/%0d busy=%b stall=%b pc_en=%b fd_en=%b de_clr=%b, want E=%0d/%0d M=%0d/%0d W=%0d/%0d busy=%b stall=%b pc_en=%b fd_en=%b de_clr=%b",
                  e.name, E_A3, E_Tnew, M_A3, M_Tnew, W_A3, W_Tnew, md_busy, stall, pc_en, fd_en, de_clr,
                  e.ea3, e.et, e.ma3, e.mt, e.wa3, e.wt, e.busy, e.st, ~e.st, ~e.st, e.st);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) check(exp_q.pop_front());
   end

   initial begin
      //   name            rst stp a3 t  ms   mu   ea et ma mt wa wt busy st
      add("rst_hold0",     1, 0,  0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      add("rst_hold1",     1, 0,  5, 3, 2'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      add("issue8",        0, 0,  8, 2, 2'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      add("e8",            0, 0,  0, 0, 2'd0, 0,   8, 2, 0, 0, 0, 0, 0, 0);
      add("stop1",         0, 1,  9, 1, 2'd0, 0,   0, 0, 8, 1, 0, 0, 0, 1);
      add("stop2",         0, 1,  9, 1, 2'd0, 0,   0, 0, 0, 0, 8, 0, 0, 1);
      add("release9",      0, 0,  9, 1, 2'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
      add("norm_in",       0, 0,  0, 3, 2'd0, 0,   9, 1, 0, 0, 0, 0, 0, 0);
      add("norm_e",        0, 0,  0, 0, 2'd0, 0,   0, 0, 9, 0, 0, 0, 0, 0);
      add("w_nowrap",      0, 0,  4, 0, 2'd0, 0,   0, 0, 0, 0, 9, 0, 0, 0);
      add("e_tnew0",       0, 0,  0, 0, 2'd0, 0,   4, 0, 0, 0, 0, 0, 0, 0);
      add("m_nowrap",      0, 0,  0, 0, 2'd0, 0,   0, 0, 4, 0, 0, 0, 0, 0);
      add("div_issue",     0, 0,  0, 0, 2'd2, 1,   0, 0, 0, 0, 4, 0, 0, 0);
      add("mflo_pend",     0, 0,  2, 1, 2'd0, 1,   0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++)
         add("div_busy",   0, 0,  2, 1, 2'd0, 1,   0, 0, 0, 0, 0, 0, 1, 1);
      add("div_done",      0, 0,  2, 1, 2'd0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
      add("mult_issue",    0, 0,  0, 0, 2'd1, 1,   2, 1, 0, 0, 0, 0, 0, 0);
      add("mflo_pend2",    0, 0,  3, 1, 2'd0, 1,   0, 0, 2, 0, 0, 0, 0, 1);
      add("mult_busy5",    0, 0,  3, 1, 2'd0, 1,   0, 0, 0, 0, 2, 0, 1, 1);
      add("mult_busy4",    0, 0,  3, 1, 2'd0, 1,   0, 0, 0, 0, 0, 0, 1, 1);
      add("rst_pulse",     2, 0,  3, 1, 2'd0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
      add("after_rst",     0, 0,  0, 0, 2'd0, 0,   3, 1, 0, 0, 0, 0, 0, 0);
      add("mult_issue2",   0, 0,  0, 0, 2'd1, 1,   0, 0, 3, 0, 0, 0, 0, 0);
      add("stop_and_pend", 0, 1,  6, 2, 2'd0, 1,   0, 0, 0, 0, 3, 0, 0, 1);
      add("stop_and_busy", 0, 1,  6, 2, 2'd0, 1,   0, 0, 0, 0, 0, 0, 1, 1);
      add("busy_only",     0, 0,  6, 2, 2'd0, 1,   0, 0, 0, 0, 0, 0, 1, 1);
      add("busy_no_use",   0, 0,  6, 2, 2'd0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
      add("illegal_op",    0, 0,  0, 0, 2'd3, 0,   6, 2, 0, 0, 0, 0, 1, 0);
      add("busy_last",     0, 0,  0, 0, 2'd0, 0,   0, 0, 6, 1, 0, 0, 1, 0);
      add("illegal_chk",   0, 0,  0, 0, 2'd0, 1,   0, 0, 0, 0, 6, 0, 0, 0);
      add("idle",          0, 0,  0, 0, 2'd0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

      reset = 1'b0; stop = 1'b0; D_A3 = '0; D_Tnew = '0; D_md_start = '0; D_md_use = 1'b0;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         reset      = (vecs[i].rst == 1) ? 1'b0 : 1'b1;
         stop       = vecs[i].stop;
         D_A3       = vecs[i].a3;
         D_Tnew     = vecs[i].tnew;
         D_md_start = vecs[i].ms;
         D_md_use   = vecs[i].mu;
         exp_q.push_back(vecs[i]);
         if (vecs[i].rst == 2) begin
            #1 reset = 1'b0;
            #5 reset = 1'b1;
         end
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by 100000, want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_pipe_tracker.md
Name: hazard_pipe_tracker

Overview:
- Sequential companion to the combinational stall comparator in the 5-stage pipeline.
- Carries each in-flight instruction's destination register (A3) and remaining result latency (Tnew) through the E, M and W stages, producing the E/M/W A3 and Tnew values the stall comparator reads.
- Consumes the comparator's stop, merges it with a multiply/divide busy stall it owns, and drives the PC/F-D enables and the D/E bubble.

Parameters:
- A3_W, 5, register-specifier width.
- T_W, 3, Tnew field width.
- MULT_CYC, 5, busy cycles after a mult/multu issues.
- DIV_CYC, 10, busy cycles after a div/divu issues.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stop  in  1  data-hazard stall from the stall comparator.
- D_A3  in  A3_W  destination of the D-stage instruction; 0 = no write.
- D_Tnew  in  T_W  Tnew of the D-stage instruction as it would enter E.
- D_md_start  in  2  D-stage MDU op: 00 none, 01 mult/multu, 10 div/divu, 11 illegal (treated as none).
- D_md_use  in  1  D-stage instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- E_A3, M_A3, W_A3  out  A3_W  per-stage destinations.
- E_Tnew, M_Tnew, W_Tnew  out  T_W  per-stage remaining latency.
- md_busy  out  1  MDU still computing.
- stall  out  1  combined stall.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D register write enable.
- de_clr  out  1  D/E register bubble.

Behaviour:
- Reset (reset=0, asynchronous):
  - All E/M/W A3 and Tnew go to 0.
  - The MDU counter goes to 0 and md_busy to 0.
  - stall follows its combinational equation; with stop=0 and D_md_use=0, stall=0.
- Combinational outputs:
  - md_stall = D_md_use & (md_busy | E_md_pending).
  - stall = stop | md_stall.
  - pc_en = fd_en = ~stall.
  - de_clr = stall.
- Every rising edge with reset=1 (no global enable; E/M/W always advance):
  - E <= stall ? {A3=0, Tnew=0} : {D_A3, D_Tnew}.
  - M <= {E_A3, sat_dec(E_Tnew)}.
  - W <= {M_A3, sat_dec(M_Tnew)}.
  - sat_dec(x) = (x==0) ? 0 : x-1. It never wraps.
- A3 normalisation: a stage with A3==0 has its Tnew forced to 0 on load, so register $0 never causes a stall.
- E_md_pending: a 1-bit register set when an MDU op (01/10) enters E without a bubble; it then drives the counter load on the next edge.
- MDU counter (width ceil(log2(DIV_CYC+1))):
  - When E_md_pending=1, the counter loads MULT_CYC or DIV_CYC according to the latched op; otherwise it decrements while nonzero.
  - md_busy = (counter != 0).
  - After a counter load of N, md_busy is high for exactly N cycles.
- A new MDU op can only reach E while the MDU is idle, because D_md_use stalls it. A load therefore never coincides with a nonzero counter.
- Simultaneous stop and md_stall: a single bubble per cycle; the behaviour is identical to either one alone.
- Reset asserted mid-operation clears the counter and all stages immediately, with no residual stall.
- W-stage Tnew reaching 0 means the value is available via the register file or forwarding. The tracker itself takes no action on it.

Test Plan:
- Reset, then D_A3=8, D_Tnew=2, stop=0 for 1 cycle, then D_A3=0 → E={8,2}, then M={8,1}, then W={8,0}; stall=0 throughout.
- stop=1 for 2 cycles with D_A3=9, D_Tnew=1 → pc_en=fd_en=0 and de_clr=1 both cycles; E={0,0} both cycles; M/W keep draining the earlier instruction.
- D_A3=0, D_Tnew=3 → E_Tnew=0 (normalised).
- E_Tnew=0 advancing → M_Tnew=0, no wrap to 7.
- D_md_start=10 accepted, then D_md_use=1 (mflo) held in D → md_busy high for 10 cycles after the load; stall=1 from the first cycle the mflo is in D until md_busy drops; mflo enters E on the first cycle md_busy=0.
- MDU counter at 3 with D_md_use=1, then reset pulsed low mid-cycle → md_busy=0, stall=0 and all stage outputs 0 immediately; after release, mflo advances on the next edge.
